demux_1x2_stream: RTL and testbench



---
 rtl/fpu_pkg.sv | 18 +
 rtl/stream_slot.sv | 78 +++++++
 rtl/demux_1x2_stream.sv | 68 ++++++
 tb/tb_demux_1x2_stream.sv | 221 ++++++++++++++++++++++
 4 files changed

// File: rtl/fpu_pkg.sv
// rtl/fpu_pkg.sv - shared constants and encodings for the stream demux slice
// Contents: default data/counter widths, channel-index encoding, slot state encoding.
package fpu_pkg;

  localparam int unsigned FPU_P  = 32;
  localparam int unsigned FPU_CW = 8;

  typedef enum logic {
    CH0 = 1'b0,
    CH1 = 1'b1
  } ch_e;

  typedef enum logic {
    SLOT_EMPTY = 1'b0,
    SLOT_FULL  = 1'b1
  } slot_state_e;

endpackage

// File: rtl/stream_slot.sv
// rtl/stream_slot.sv - single-entry valid/ready holding register with delivered-word counter
// Ports:
//   clk, rst_n          clock, asynchronous active-low reset
//   wr_en, wr_data      write strobe (only asserted while wr_ready=1) and word
//   wr_ready            slot can take a word this cycle (empty, or draining now)
//   out_valid/out_ready consumer handshake; out_data is the held word
//   clr_cnt, cnt        synchronous counter clear, words delivered modulo 2^CW
module stream_slot
  import fpu_pkg::*;
#(
  parameter int unsigned P  = FPU_P,
  parameter int unsigned CW = FPU_CW
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          wr_en,
  input  logic [P-1:0]  wr_data,
  output logic          wr_ready,
  output logic          out_valid,
  input  logic          out_ready,
  output logic [P-1:0]  out_data,
  input  logic          clr_cnt,
  output logic [CW-1:0] cnt
);

  slot_state_e   state_q, state_d;
  logic [P-1:0]  data_q, data_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic          hs;

  // State register plus datapath registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= SLOT_EMPTY;
      data_q  <= '0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      data_q  <= data_d;
      cnt_q   <= cnt_d;
    end
  end

  assign hs = (state_q == SLOT_FULL) && out_ready;

  // Next state: a write while full only happens together with a drain,
  // so the slot stays full and the word passes through without a bubble.
  always_comb begin
    state_d = state_q;
    case (state_q)
      SLOT_EMPTY: if (wr_en) state_d = SLOT_FULL;
      SLOT_FULL:  if (hs && !wr_en) state_d = SLOT_EMPTY;
      default:    state_d = SLOT_EMPTY;
    endcase
  end

  // Data keeps its last value after a drain; only a write replaces it.
  always_comb begin
    data_d = data_q;
    if (wr_en) data_d = wr_data;
  end

  // Clear has priority over a same-cycle delivery.
  always_comb begin
    cnt_d = cnt_q;
    if (clr_cnt)  cnt_d = '0;
    else if (hs)  cnt_d = cnt_q + CW'(1);
  end

  // Outputs: valid comes from state only, never from out_ready.
  always_comb begin
    out_valid = (state_q == SLOT_FULL);
    wr_ready  = (state_q == SLOT_EMPTY) || out_ready;
    out_data  = data_q;
    cnt       = cnt_q;
  end

endmodule

// File: rtl/demux_1x2_stream.sv
// rtl/demux_1x2_stream.sv - registered 1-to-2 stream demultiplexer with per-channel counters
// Ports:
//   clk, rst                     clock, asynchronous active-low reset
//   in_valid, in_ready, MS, D_in producer side; MS picks channel 0 or 1
//   out_valid_k, out_ready_k,
//   D_out_k                      channel k consumer side (k = 0, 1)
//   clr_cnt, cnt_0, cnt_1        counter clear, delivered-word counts
module demux_1x2_stream
  import fpu_pkg::*;
#(
  parameter int unsigned P  = FPU_P,
  parameter int unsigned CW = FPU_CW
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          in_valid,
  output logic          in_ready,
  input  logic          MS,
  input  logic [P-1:0]  D_in,
  output logic          out_valid_0,
  input  logic          out_ready_0,
  output logic [P-1:0]  D_out_0,
  output logic          out_valid_1,
  input  logic          out_ready_1,
  output logic [P-1:0]  D_out_1,
  input  logic          clr_cnt,
  output logic [CW-1:0] cnt_0,
  output logic [CW-1:0] cnt_1
);

  logic slot_ready_0, slot_ready_1;
  logic acc_0, acc_1;
  logic sel_ch1;

  assign sel_ch1 = (MS == CH1);

  // Only the selected channel can stall the producer.
  assign in_ready = sel_ch1 ? slot_ready_1 : slot_ready_0;
  assign acc_0    = in_valid && in_ready && !sel_ch1;
  assign acc_1    = in_valid && in_ready &&  sel_ch1;

  stream_slot #(.P(P), .CW(CW)) u_slot_0 (
    .clk       (clk),
    .rst_n     (rst),
    .wr_en     (acc_0),
    .wr_data   (D_in),
    .wr_ready  (slot_ready_0),
    .out_valid (out_valid_0),
    .out_ready (out_ready_0),
    .out_data  (D_out_0),
    .clr_cnt   (clr_cnt),
    .cnt       (cnt_0)
  );

  stream_slot #(.P(P), .CW(CW)) u_slot_1 (
    .clk       (clk),
    .rst_n     (rst),
    .wr_en     (acc_1),
    .wr_data   (D_in),
    .wr_ready  (slot_ready_1),
    .out_valid (out_valid_1),
    .out_ready (out_ready_1),
    .out_data  (D_out_1),
    .clr_cnt   (clr_cnt),
    .cnt       (cnt_1)
  );

endmodule

// File: tb/tb_demux_1x2_stream.sv
// tb/tb_demux_1x2_stream.sv - self-checking bench for demux_1x2_stream
module tb_demux_1x2_stream;

  localparam int unsigned P  = 32;
  localparam int unsigned CW = 4;

  logic          clk = 1'b0;
  logic          rst;
  logic          in_valid;
  logic          in_ready;
  logic          MS;
  logic [P-1:0]  D_in;
  logic          out_valid_0, out_ready_0;
  logic [P-1:0]  D_out_0;
  logic          out_valid_1, out_ready_1;
  logic [P-1:0]  D_out_1;
  logic          clr_cnt;
  logic [CW-1:0] cnt_0, cnt_1;

  demux_1x2_stream #(.P(P), .CW(CW)) dut (
    .clk         (clk),
    .rst         (rst),
    .in_valid    (in_valid),
    .in_ready    (in_ready),
    .MS          (MS),
    .D_in        (D_in),
    .out_valid_0 (out_valid_0),
    .out_ready_0 (out_ready_0),
    .D_out_0     (D_out_0),
    .out_valid_1 (out_valid_1),
    .out_ready_1 (out_ready_1),
    .D_out_1     (D_out_1),
    .clr_cnt     (clr_cnt),
    .cnt_0       (cnt_0),
    .cnt_1       (cnt_1)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic        v;
    logic        ms;
    logic [31:0] d;
    logic        r0;
    logic        r1;
    logic        clr;
    logic        exp_rdy;
  } vec_t;

  vec_t vecs[14];

  int checks   = 0;
  int failures = 0;

  // Reference model: channel occupancy, counters and per-channel scoreboards.
  logic          m_full0, m_full1;
  logic [CW-1:0] m_cnt0, m_cnt1;
  logic [P-1:0]  q0[$];
  logic [P-1:0]  q1[$];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%h required=%h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_full0 = 1'b0;
    m_full1 = 1'b0;
    m_cnt0  = '0;
    m_cnt1  = '0;
    q0.delete();
    q1.delete();
  endtask

  // One clock cycle: drive at negedge, check, advance model, return at posedge.
  task automatic cycle(input logic v, input logic ms, input logic [31:0] d,
                       input logic r0, input logic r1, input logic clr,
                       input logic exp_rdy);
    logic hs0, hs1, m_rdy, acc;
    @(negedge clk);
    in_valid    = v;
    MS          = ms;
    D_in        = d;
    out_ready_0 = r0;
    out_ready_1 = r1;
    clr_cnt     = clr;
    #1;
    chk("in_ready", {31'd0, in_ready}, {31'd0, exp_rdy});
    chk("out_valid_0", {31'd0, out_valid_0}, {31'd0, m_full0});
    chk("out_valid_1", {31'd0, out_valid_1}, {31'd0, m_full1});
    chk("cnt_0", 32'(cnt_0), 32'(m_cnt0));
    chk("cnt_1", 32'(cnt_1), 32'(m_cnt1));
    if (m_full0) begin
      if (q0.size() == 0) begin
        checks++; failures++;
        $display("FAIL sb_q0 actual=empty required=entry at %0t", $time);
      end else chk("D_out_0", D_out_0, q0[0]);
    end
    if (m_full1) begin
      if (q1.size() == 0) begin
        checks++; failures++;
        $display("FAIL sb_q1 actual=empty required=entry at %0t", $time);
      end else chk("D_out_1", D_out_1, q1[0]);
    end
    hs0   = m_full0 & r0;
    hs1   = m_full1 & r1;
    m_rdy = ms ? (!m_full1 | r1) : (!m_full0 | r0);
    acc   = v & m_rdy;
    if (hs0 && q0.size() > 0) void'(q0.pop_front());
    if (hs1 && q1.size() > 0) void'(q1.pop_front());
    if (acc && !ms) q0.push_back(d);
    if (acc &&  ms) q1.push_back(d);
    m_full0 = (acc & !ms) | (m_full0 & !hs0);
    m_full1 = (acc &  ms) | (m_full1 & !hs1);
    m_cnt0  = clr ? '0 : (hs0 ? m_cnt0 + CW'(1) : m_cnt0);
    m_cnt1  = clr ? '0 : (hs1 ? m_cnt1 + CW'(1) : m_cnt1);
    @(posedge clk);
  endtask

  task automatic run_vecs(input int lo, input int hi);
    for (int i = lo; i <= hi; i++)
      cycle(vecs[i].v, vecs[i].ms, vecs[i].d, vecs[i].r0, vecs[i].r1,
            vecs[i].clr, vecs[i].exp_rdy);
  endtask

  initial begin
    int exp16;
    //          v     ms    data          r0    r1    clr   rdy
    vecs[0]  = '{1'b1, 1'b0, 32'h11111111, 1'b1, 1'b1, 1'b0, 1'b1};
    vecs[1]  = '{1'b1, 1'b1, 32'h22222222, 1'b1, 1'b1, 1'b0, 1'b1};
    vecs[2]  = '{1'b0, 1'b0, 32'h00000000, 1'b1, 1'b1, 1'b0, 1'b1};
    vecs[3]  = '{1'b1, 1'b0, 32'hAAAA0001, 1'b0, 1'b1, 1'b0, 1'b1};
    vecs[4]  = '{1'b1, 1'b0, 32'hAAAA0002, 1'b0, 1'b1, 1'b0, 1'b0};
    vecs[5]  = '{1'b1, 1'b1, 32'hBBBB0001, 1'b0, 1'b1, 1'b0, 1'b1};
    vecs[6]  = '{1'b0, 1'b1, 32'h00000000, 1'b0, 1'b1, 1'b0, 1'b1};
    vecs[7]  = '{1'b0, 1'b0, 32'h00000000, 1'b1, 1'b1, 1'b0, 1'b1};
    vecs[8]  = '{1'b0, 1'b0, 32'h00000000, 1'b1, 1'b1, 1'b0, 1'b1};
    vecs[9]  = '{1'b1, 1'b0, 32'h0000000A, 1'b0, 1'b1, 1'b0, 1'b1};
    vecs[10] = '{1'b1, 1'b0, 32'h0000000B, 1'b1, 1'b1, 1'b0, 1'b1};
    vecs[11] = '{1'b0, 1'b0, 32'h00000000, 1'b0, 1'b1, 1'b0, 1'b0};
    vecs[12] = '{1'b0, 1'b0, 32'h00000000, 1'b1, 1'b1, 1'b0, 1'b1};
    vecs[13] = '{1'b0, 1'b0, 32'h00000000, 1'b1, 1'b1, 1'b0, 1'b1};

    rst = 1'b0; in_valid = 1'b0; MS = 1'b0; D_in = '0;
    out_ready_0 = 1'b0; out_ready_1 = 1'b0; clr_cnt = 1'b0;
    model_reset();
    #1;
    chk("rst_out_valid_0", {31'd0, out_valid_0}, 32'd0);
    chk("rst_out_valid_1", {31'd0, out_valid_1}, 32'd0);
    chk("rst_D_out_0", D_out_0, 32'd0);
    chk("rst_D_out_1", D_out_1, 32'd0);
    chk("rst_in_ready", {31'd0, in_ready}, 32'd1);
    @(negedge clk);
    rst = 1'b1;

    // Basic routing.
    run_vecs(0, 2);
    #2;
    chk("route_cnt_0", 32'(cnt_0), 32'd1);
    chk("route_cnt_1", 32'(cnt_1), 32'd1);

    // Backpressure isolation, then drain-and-refill without a bubble.
    run_vecs(3, 13);
    #2;
    chk("bp_cnt_0", 32'(cnt_0), 32'd4);
    chk("bp_cnt_1", 32'(cnt_1), 32'd2);

    // Streaming 16 words on channel 1.
    cycle(1'b0, 1'b1, 32'h0, 1'b1, 1'b1, 1'b1, 1'b1);
    for (int i = 0; i < 16; i++)
      cycle(1'b1, 1'b1, 32'h100 + 32'(i), 1'b1, 1'b1, 1'b0, 1'b1);
    cycle(1'b0, 1'b1, 32'h0, 1'b1, 1'b1, 1'b0, 1'b1);
    #2;
    exp16 = 16 % (1 << CW);
    chk("stream_cnt_1", 32'(cnt_1), 32'(exp16));

    // Counter wrap: 17 deliveries on channel 0.
    cycle(1'b0, 1'b0, 32'h0, 1'b1, 1'b1, 1'b1, 1'b1);
    for (int i = 0; i < 17; i++)
      cycle(1'b1, 1'b0, 32'h200 + 32'(i), 1'b1, 1'b1, 1'b0, 1'b1);
    cycle(1'b0, 1'b0, 32'h0, 1'b1, 1'b1, 1'b0, 1'b1);
    #2;
    chk("wrap_cnt_0", 32'(cnt_0), 32'd1);

    // Clear coinciding with a delivery.
    cycle(1'b1, 1'b0, 32'h300, 1'b1, 1'b1, 1'b0, 1'b1);
    cycle(1'b0, 1'b0, 32'h0, 1'b1, 1'b1, 1'b1, 1'b1);
    #2;
    chk("clr_hs_cnt_0", 32'(cnt_0), 32'd0);
    chk("clr_hs_out_valid_0", {31'd0, out_valid_0}, 32'd0);

    // Reset while channel 0 holds a stalled word.
    cycle(1'b1, 1'b0, 32'h400, 1'b1, 1'b1, 1'b0, 1'b1);
    cycle(1'b1, 1'b0, 32'hDEADBEEF, 1'b1, 1'b1, 1'b0, 1'b1);
    #2;
    in_valid = 1'b0; MS = 1'b0; out_ready_0 = 1'b0; clr_cnt = 1'b0;
    chk("pre_rst_D_out_0", D_out_0, 32'hDEADBEEF);
    chk("pre_rst_cnt_0", 32'(cnt_0), 32'd1);
    rst = 1'b0;
    #1;
    chk("mid_rst_out_valid_0", {31'd0, out_valid_0}, 32'd0);
    chk("mid_rst_D_out_0", D_out_0, 32'd0);
    chk("mid_rst_D_out_1", D_out_1, 32'd0);
    chk("mid_rst_cnt_0", 32'(cnt_0), 32'd0);
    chk("mid_rst_in_ready", {31'd0, in_ready}, 32'd1);
    model_reset();
    @(negedge clk);
    rst = 1'b1;
    cycle(1'b1, 1'b0, 32'h500, 1'b1, 1'b1, 1'b0, 1'b1);
    cycle(1'b0, 1'b0, 32'h0, 1'b1, 1'b1, 1'b0, 1'b1);
    #2;
    chk("post_rst_cnt_0", 32'(cnt_0), 32'd1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
